serial_slave_port: RTL
======================

# serial_slave_port

Responder end of the bit-serial system bus: deserializes the address and write-data bitstream driven by a master through the serial bus, performs a single-beat access on a parallel memory-side port, and serializes read data back onto the bus. It sits between a `serial_bus` slave channel (`sN_*` wires) and a slave memory array, and gives any slave the bus-facing half of the protocol, including optional split handling.

## Interface
- `ADDR_WIDTH`, 12, slave-local address bits received serially
- `DATA_WIDTH`, 8, data bits per beat
- `SPLIT_DELAY`, 200, cycles held in split before requesting re-grant (only with split compiled in)
- `clk`  in  1  clock; all state changes on rising edge
- `rstn`  in  1  asynchronous, active-low reset
- `bwdata`  in  1  serial address/write-data bit, LSB first
- `bmode`  in  1  1 = write, 0 = read; sampled with address bit 0
- `bwvalid`  in  1  `bwdata` bit valid this cycle
- `brdata`  out  1  serial read-data bit, LSB first
- `brvalid`  out  1  `brdata` valid this cycle
- `sready`  out  1  port idle and able to accept address bit 0
- `split_grant`  in  1  bus re-grant after a split
- `ssplit`  out  1  split request/indication
- `mem_addr`  out  ADDR_WIDTH  captured address, held until the next address is captured
- `mem_wdata`  out  DATA_WIDTH  captured write data
- `mem_wen`  out  1  one-cycle write strobe
- `mem_ren`  out  1  one-cycle read strobe
- `mem_rdata`  in  DATA_WIDTH  read data, valid with `mem_rvalid`
- `mem_rvalid`  in  1  read data valid; may assert 1 or more cycles after `mem_ren`

## Operation
- States: IDLE, ADDR, WDATA, MEMWR, MEMRD, SPLIT, GRANT_WAIT, RDATA.
- IDLE: `sready`=1. `bwvalid`=1 captures address bit 0 and latches `bmode`, then moves to ADDR.
- ADDR: each `bwvalid` cycle shifts in the next bit. Cycles without `bwvalid` are gaps: no shift, no count.
- After bit ADDR_WIDTH-1:
  - write goes to WDATA;
  - read goes to MEMRD, or to SPLIT when split is compiled in.
- WDATA: collects DATA_WIDTH bits, LSB first, then goes to MEMWR.
- MEMWR: `mem_wen`=1 for exactly one cycle, then IDLE.
- MEMRD: `mem_ren`=1 for one cycle, then waits for `mem_rvalid`. `mem_rdata` is latched into the shift register, then RDATA.
- RDATA: `brvalid`=1 for DATA_WIDTH consecutive cycles with no gaps, bit i on cycle i; then IDLE.
- Bit counter: width `$clog2(max(ADDR_WIDTH,DATA_WIDTH))+1`; cleared on every state change.
- Ignored inputs:
  - `bwvalid` outside IDLE/ADDR/WDATA;
  - `mem_rvalid` outside MEMRD after the strobe;
  - `split_grant` outside GRANT_WAIT.
- `sready`=0 in every state except IDLE.
- Reset (any state, mid-transfer included): returns to IDLE, discards partial address and data, no memory strobe.
- Reset values: `sready`=1, `brdata`=0, `brvalid`=0, `ssplit`=0, `mem_wen`=0, `mem_ren`=0, `mem_addr`=0, `mem_wdata`=0.

## Timing
- Write, last data bit sampled at edge N:
  - `mem_wen`=1 during cycle N+1;
  - `sready`=1 at N+2.
- Read, no split, last address bit at edge N:
  - `mem_ren`=1 during cycle N+1;
  - `mem_rvalid` sampled at edge M (M ≥ N+2);
  - `brvalid`=1 during cycles M+1 … M+DATA_WIDTH;
  - `sready`=1 at M+DATA_WIDTH+1.
- All outputs are registered; no combinational input-to-output path.
- `mem_rvalid` in the same cycle as `mem_ren` is not legal; the port samples it from the following cycle.

## Configuration
- `SERIAL_SLAVE_SPLIT_EN` defined:
  - reads enter SPLIT after the last address bit, with `ssplit`=1 for exactly one cycle;
  - SPLIT counts SPLIT_DELAY cycles, then goes to GRANT_WAIT;
  - GRANT_WAIT drives `ssplit`=1 (level) until `split_grant`=1 is sampled, then `ssplit`=0 and the port goes to MEMRD;
  - writes are never split.
- `SERIAL_SLAVE_SPLIT_EN` undefined:
  - SPLIT and GRANT_WAIT are not built;
  - `ssplit` is tied 0;
  - `split_grant` is ignored;
  - reads go directly to MEMRD.

## Test plan
- Write: addr 0xA5C, data 0x3C serial LSB first, no gaps -> `mem_wen` pulses once with `mem_addr`=0xA5C, `mem_wdata`=0x3C; `sready` returns 1 two cycles after the last bit.
- Read: addr 0x123, memory model returns 0x96 two cycles after `mem_ren` -> `brdata` sequence 0,1,1,0,1,0,0,1 on 8 consecutive `brvalid` cycles.
- Gapped write: addr 0x001, data 0xFF, with `bwvalid` low for 3 cycles mid-address and 2 cycles mid-data -> identical capture: `mem_addr`=0x001, `mem_wdata`=0xFF, single `mem_wen`.
- Reset mid-op: `rstn` low after 5 address bits -> all outputs at reset values, `sready`=1; a following full write of 0x7FF/0x55 completes correctly.
- Split read (`SERIAL_SLAVE_SPLIT_EN`, SPLIT_DELAY=10): addr 0x400, `split_grant` asserted 5 cycles after `ssplit` rises in GRANT_WAIT ->
  - `mem_ren` exactly one cycle after the grant is sampled;
  - read data is then returned serially;
  - `split_grant` pulsed during SPLIT has no effect.
- Spurious inputs: `mem_rvalid`=1 in IDLE and `bwvalid`=1 during RDATA -> no state change, no strobe, no corruption of the shifted-out byte.

Source files
------------

// File: rtl/serial_slave_port.sv
// Bus-facing responder: serial address/data in, one memory beat, serial read data out.
// Optional split handling for reads is compiled in with SERIAL_SLAVE_SPLIT_EN.
module serial_slave_port #(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 8,
  parameter int SPLIT_DELAY = 200
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  bwdata,
  input  logic                  bmode,
  input  logic                  bwvalid,
  output logic                  brdata,
  output logic                  brvalid,
  output logic                  sready,
  input  logic                  split_grant,
  output logic                  ssplit,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_wen,
  output logic                  mem_ren,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_rvalid
);

  localparam int MAXW = (ADDR_WIDTH > DATA_WIDTH) ?
                        ADDR_WIDTH : DATA_WIDTH;
  localparam int CW   = $clog2(MAXW) + 1;

  typedef enum logic [2:0] {
    IDLE, ADDR, WDATA, MEMWR,
    MEMRD, SPLIT, GRANT_WAIT, RDATA
  } state_t;

  state_t                state, state_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic                  mode, mode_n;
  logic [ADDR_WIDTH-2:0] addr_sr, addr_n;
  logic [DATA_WIDTH-1:0] data_sr, data_n;
  logic [ADDR_WIDTH-1:0] maddr_n;
  logic [DATA_WIDTH-1:0] mwdata_n;
  logic                  wen_n, ren_n;
  logic                  brdata_n, brvalid_n;
  logic                  ssplit_n, sready_n;

`ifdef SERIAL_SLAVE_SPLIT_EN
  localparam int SW = $clog2(SPLIT_DELAY + 1);
  logic [SW-1:0] scnt, scnt_n;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) scnt <= '0;
    else       scnt <= scnt_n;
  end
`else
  logic [1:0] unused_split;
  assign unused_split = {split_grant, 1'(SPLIT_DELAY)};
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= '0;
      mode      <= 1'b0;
      addr_sr   <= '0;
      data_sr   <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wen   <= 1'b0;
      mem_ren   <= 1'b0;
      brdata    <= 1'b0;
      brvalid   <= 1'b0;
      ssplit    <= 1'b0;
      sready    <= 1'b1;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      mode      <= mode_n;
      addr_sr   <= addr_n;
      data_sr   <= data_n;
      mem_addr  <= maddr_n;
      mem_wdata <= mwdata_n;
      mem_wen   <= wen_n;
      mem_ren   <= ren_n;
      brdata    <= brdata_n;
      brvalid   <= brvalid_n;
      ssplit    <= ssplit_n;
      sready    <= sready_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    mode_n    = mode;
    addr_n    = addr_sr;
    data_n    = data_sr;
    maddr_n   = mem_addr;
    mwdata_n  = mem_wdata;
    wen_n     = 1'b0;
    ren_n     = 1'b0;
    brdata_n  = 1'b0;
    brvalid_n = 1'b0;
    ssplit_n  = 1'b0;
`ifdef SERIAL_SLAVE_SPLIT_EN
    scnt_n    = scnt;
`endif
    case (state)
      IDLE: begin
        if (bwvalid) begin
          addr_n  = {bwdata, addr_sr[ADDR_WIDTH-2:1]};
          mode_n  = bmode;
          state_n = ADDR;
        end
      end
      ADDR: begin
        if (bwvalid) begin
          cnt_n = cnt + 1'b1;
          if (cnt == CW'(ADDR_WIDTH - 2)) begin
            maddr_n = {bwdata, addr_sr};
            if (mode) begin
              state_n = WDATA;
            end else begin
`ifdef SERIAL_SLAVE_SPLIT_EN
              state_n  = SPLIT;
              ssplit_n = 1'b1;
`else
              state_n = MEMRD;
              ren_n   = 1'b1;
`endif
            end
          end else begin
            addr_n = {bwdata, addr_sr[ADDR_WIDTH-2:1]};
          end
        end
      end
      WDATA: begin
        if (bwvalid) begin
          data_n = {bwdata, data_sr[DATA_WIDTH-1:1]};
          cnt_n  = cnt + 1'b1;
          if (cnt == CW'(DATA_WIDTH - 1)) begin
            mwdata_n = data_n;
            wen_n    = 1'b1;
            state_n  = MEMWR;
          end
        end
      end
      MEMWR: state_n = IDLE;
      MEMRD: begin
        // rvalid during the strobe cycle itself is not a response
        if (!mem_ren && mem_rvalid) begin
          data_n    = mem_rdata;
          brdata_n  = mem_rdata[0];
          brvalid_n = 1'b1;
          state_n   = RDATA;
        end
      end
      RDATA: begin
        if (cnt == CW'(DATA_WIDTH - 1)) begin
          state_n = IDLE;
        end else begin
          cnt_n     = cnt + 1'b1;
          data_n    = {data_sr[0], data_sr[DATA_WIDTH-1:1]};
          brdata_n  = data_sr[1];
          brvalid_n = 1'b1;
        end
      end
`ifdef SERIAL_SLAVE_SPLIT_EN
      SPLIT: begin
        scnt_n = scnt + 1'b1;
        if (scnt == SW'(SPLIT_DELAY - 1)) begin
          state_n  = GRANT_WAIT;
          ssplit_n = 1'b1;
        end
      end
      GRANT_WAIT: begin
        ssplit_n = 1'b1;
        if (split_grant) begin
          ssplit_n = 1'b0;
          ren_n    = 1'b1;
          state_n  = MEMRD;
        end
      end
`endif
      default: state_n = IDLE;
    endcase
    if (state_n != state) begin
      cnt_n = '0;
`ifdef SERIAL_SLAVE_SPLIT_EN
      scnt_n = '0;
`endif
    end
    sready_n = (state_n == IDLE);
  end

endmodule
